seq_multiplier: RTL

- Iterative unsigned shift-add multiplier. It is the multiply counterpart to the posit datapath's sequential restoring divider.
- Forms the double-width significand product for the posit multiply path, one multiplier bit per clock.
- Uses a start/busy/done handshake so the posit control FSM can launch an operation and wait for it.
- Area-lean alternative to a combinational array multiplier.

---
 rtl/posit_arith_pkg.sv | 16 +
 rtl/seq_multiplier.sv | 97 +++++++++
 2 files changed

// File: rtl/posit_arith_pkg.sv
// Shared posit arithmetic definitions: default significand width, multiplier FSM states and
// count-width helper used by the sequential multiplier and divider.
package posit_arith_pkg;

  localparam int SIG_WIDTH = 25;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } mult_state_t;

  function automatic int cnt_width(input int w);
    return $clog2(w + 1);
  endfunction

endpackage

// File: rtl/seq_multiplier.sv
// Iterative unsigned shift-add multiplier, one multiplier bit per clock; done pulses width cycles
// after the accepting edge, starts are ignored while busy. Optional MULT_ZERO_BYPASS_EN finishes zero operands in 1 cycle.
module seq_multiplier
  import posit_arith_pkg::*;
#(
  parameter int width = SIG_WIDTH
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [width-1:0]   a,
  input  logic [width-1:0]   b,
  output logic [2*width-1:0] p,
  output logic               busy,
  output logic               done
);

  localparam int CW = cnt_width(width);

  mult_state_t      state, state_next;
  logic [width-1:0] acc, mcand, mplier;
  logic [width-1:0] acc_next, mplier_next;
  logic [width:0]   sum;
  logic [CW-1:0]    count;
  logic             accept, finish, zero_op;

  // One iteration: conditional add with carry, then shift {sum,mplier} right by one.
  always_comb begin
    sum         = {1'b0, acc} + (mplier[0] ? {1'b0, mcand} : '0);
    acc_next    = sum[width:1];
    mplier_next = {sum[0], mplier[width-1:1]};
  end

  always_comb begin
    state_next = state;
    accept     = 1'b0;
    finish     = 1'b0;
    zero_op    = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          accept = 1'b1;
`ifdef MULT_ZERO_BYPASS_EN
          zero_op = (a == '0) || (b == '0);
`endif
          if (!zero_op) state_next = RUN;
        end
      end
      RUN: begin
        if (count == CW'(width - 1)) begin
          finish     = 1'b1;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= IDLE;
      p      <= '0;
      busy   <= 1'b0;
      done   <= 1'b0;
      acc    <= '0;
      mcand  <= '0;
      mplier <= '0;
      count  <= '0;
    end else begin
      state <= state_next;
      done  <= 1'b0;
      if (accept) begin
        if (zero_op) begin
          p    <= '0;
          done <= 1'b1;
        end else begin
          mcand  <= a;
          mplier <= b;
          acc    <= '0;
          count  <= '0;
          busy   <= 1'b1;
        end
      end
      if (state == RUN) begin
        acc    <= acc_next;
        mplier <= mplier_next;
        count  <= count + CW'(1);
        if (finish) begin
          p    <= {acc_next, mplier_next};
          busy <= 1'b0;
          done <= 1'b1;
        end
      end
    end
  end

endmodule
